// File: rtl/fpu_mant_sub_norm.sv
// -----------------------------------------------------------------------------
// fpu_mant_sub_norm
//
// Sequential mantissa subtract-and-normalise unit for the effective-subtraction
// path of the FPU. Computes |A - B| on 24-bit aligned mantissas, one 4-bit
// group per cycle with a chained borrow, takes the two's-complement magnitude
// when the result is negative, then normalises with one left shift per cycle
// until bit 23 is set.
//
// Optional feature macro: FPU_NORM_DENORM_EN
//   defined   - normalisation stops at exponent 1, leaving a denormal (UF=1)
//   undefined - normalisation always reaches F[23]=1, exponent wraps, UF=0
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   operation request, sampled only in IDLE
//   A      in  24   minuend mantissa (aligned)
//   B      in  24   subtrahend mantissa (aligned)
//   E      in   8   common exponent of the aligned operands
//   busy   out  1   high in every state except IDLE
//   done   out  1   one-cycle pulse when results are valid
//   F      out 24   normalised magnitude
//   Eo     out  8   adjusted exponent
//   Sh     out  5   number of left shifts applied
//   S      out  1   result sign (1 when B > A)
//   Z      out  1   result is exactly zero
//   UF     out  1   normalisation stopped at the exponent floor
// -----------------------------------------------------------------------------
module fpu_mant_sub_norm (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] A,
    input  logic [23:0] B,
    input  logic [7:0]  E,
    output logic        busy,
    output logic        done,
    output logic [23:0] F,
    output logic [7:0]  Eo,
    output logic [4:0]  Sh,
    output logic        S,
    output logic        Z,
    output logic        UF
);

    typedef enum logic [2:0] {IDLE, SUB, NEG, NORM, DONE} state_t;

    state_t      state;
    logic [23:0] a_reg;
    logic [23:0] b_reg;
    logic [7:0]  e_reg;
    logic [2:0]  g;          // current 4-bit group index, 0..5
    logic        chain;      // borrow in SUB, carry in NEG

    logic [4:0]  sub_res;    // bit 4 is the borrow out of the group
    logic [4:0]  neg_res;    // bit 4 is the carry out of the group
    logic [4:0]  grp_lsb;
    logic        last_grp;
    logic        stop_norm;

    // NOTE: every variable written in always_comb gets a value on every path
    // (here unconditionally), so no latch can be inferred.
    always_comb begin
        grp_lsb  = {g, 2'b00};
        sub_res  = {1'b0, a_reg[grp_lsb +: 4]} - {1'b0, b_reg[grp_lsb +: 4]} - {4'b0, chain};
        neg_res  = {1'b0, ~F[grp_lsb +: 4]} + {4'b0, chain};
        last_grp = (g == 3'd5);
`ifdef FPU_NORM_DENORM_EN
        // Eo <= 1 also covers an entry exponent of 0 or 1: no shift at all.
        stop_norm = (Eo <= 8'd1);
`else
        stop_norm = 1'b0;
`endif
    end

`ifndef FPU_NORM_DENORM_EN
    assign UF = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            e_reg <= '0;
            g     <= '0;
            chain <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            F     <= '0;
            Eo    <= '0;
            Sh    <= '0;
            S     <= 1'b0;
            Z     <= 1'b0;
`ifdef FPU_NORM_DENORM_EN
            UF    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        e_reg <= E;
                        chain <= 1'b0;
                        g     <= '0;
                        Sh    <= '0;
                        S     <= 1'b0;
                        Z     <= 1'b0;
`ifdef FPU_NORM_DENORM_EN
                        UF    <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end

                SUB: begin
                    F[grp_lsb +: 4] <= sub_res[3:0];
                    chain           <= sub_res[4];
                    if (last_grp) begin
                        g <= '0;
                        if (sub_res[4]) begin
                            // Negative difference: carry-in of 1 for the
                            // two's-complement pass.
                            S     <= 1'b1;
                            chain <= 1'b1;
                            state <= NEG;
                        end else if (F[19:0] == 20'd0 && sub_res[3:0] == 4'd0) begin
                            Z     <= 1'b1;
                            Eo    <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            Eo    <= e_reg;
                            state <= NORM;
                        end
                    end else begin
                        g <= g + 3'd1;
                    end
                end

                NEG: begin
                    F[grp_lsb +: 4] <= neg_res[3:0];
                    chain           <= neg_res[4];
                    if (last_grp) begin
                        g     <= '0;
                        Eo    <= e_reg;
                        state <= NORM;
                    end else begin
                        g <= g + 3'd1;
                    end
                end

                NORM: begin
                    if (F[23]) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (stop_norm) begin
`ifdef FPU_NORM_DENORM_EN
                        UF    <= 1'b1;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        F  <= {F[22:0], 1'b0};
                        Sh <= Sh + 5'd1;
                        Eo <= Eo - 8'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_mant_sub_norm.md
# fpu_mant_sub_norm

Sequential mantissa subtract-and-normalise unit for the effective-subtraction path of the floating-point unit. It computes |A − B| on 24-bit aligned mantissas and returns the magnitude, sign and adjusted exponent, normalised so that bit 23 is set.
- The subtraction runs serially, one 4-bit group per cycle with the borrow chained between groups, the reverse of the grouped carry-lookahead addition path.
- Normalisation is one left shift per cycle.

## Interface
Parameters: none (width fixed at 24-bit mantissa, 8-bit exponent).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- A  input  24  minuend mantissa (aligned).
- B  input  24  subtrahend mantissa (aligned).
- E  input  8  common exponent of the aligned operands.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are valid.
- F  output  24  normalised magnitude.
- Eo  output  8  adjusted exponent.
- Sh  output  5  number of left shifts applied.
- S  output  1  result sign: 1 when B > A.
- Z  output  1  result is exactly zero.
- UF  output  1  normalisation stopped at the exponent floor (see Configuration).

## Operation
- States: IDLE, SUB, NEG, NORM, DONE.
- IDLE
  - start=1 captures A, B and E, clears the borrow, the group index g, Sh and UF, then goes to SUB.
  - start=0 stays in IDLE.
- SUB, six cycles, g = 0..5:
  - Each cycle computes F[4g+3:4g] = A grp − B grp − borrow and updates the borrow.
  - After g=5:
    - If the final borrow is 1: S=1, go to NEG.
    - Else if F==0: Z=1, S=0, Eo=0, go to DONE.
    - Else go to NORM.
- NEG, six cycles:
  - Each cycle computes F grp = ~F grp + carry, with carry-in 1 at g=0, forming the two's-complement magnitude.
  - Then go to NORM. The result is never zero here.
- NORM
  - If F[23]=1, go to DONE.
  - Else if the stop condition is met (Configuration), set UF=1 and go to DONE.
  - Otherwise: F ← F<<1, Sh ← Sh+1, Eo ← Eo−1.
  - Eo is loaded with E on entry to NORM.
- DONE: done=1 for one cycle; go to IDLE.
- Holding and restarting:
  - F, Eo, Sh, S, Z and UF hold their values until the next accepted start.
  - start is ignored while busy=1.
- Reset mid-operation: the next state is IDLE, all outputs go to 0 and no done pulse is produced.
- Reset values: busy=0, done=0, F=0, Eo=0, Sh=0, S=0, Z=0, UF=0.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Let n=1 if the subtraction borrows, else 0. Let k be the number of shifts applied.
- Non-zero result: done is high in cycle 8 + 6n + k.
- Zero result: done is high in cycle 7.
- Shift count: k ≤ 23 without the feature. NORM occupies k+1 cycles.
- Worst case is 37 cycles (n=1, k=23).
- busy rises in cycle 1 and falls in the cycle after done.

## Configuration
- FPU_NORM_DENORM_EN defined:
  - NORM stops when Eo == 1 and F[23]=0, leaving a denormal result. UF=1 in that case.
  - If E ≤ 1 at entry, no shift occurs.
- FPU_NORM_DENORM_EN undefined:
  - NORM shifts until F[23]=1 regardless of the exponent.
  - Eo = (E − k) mod 256, so it wraps.
  - UF is tied to 0.

## Test plan
- A=B=0x123456, E=0x80 -> done in cycle 7; F=0, Z=1, S=0, Eo=0, Sh=0.
- A=0x800000, B=0x400000, E=0x80 -> done in cycle 9; F=0x800000, S=0, Eo=0x7F, Sh=1.
- A=0x400000, B=0x800000, E=0x80 -> done in cycle 15; F=0x800000, S=1, Eo=0x7F, Sh=1.
- A=0x800000, B=0x7FFFF0, E=3:
  - With FPU_NORM_DENORM_EN: done in cycle 10; F=0x000040, Eo=1, Sh=2, UF=1.
  - Without it: done in cycle 27; F=0x800000, Eo=0xF0, Sh=19, UF=0.
- start while busy is ignored:
  - Setup: start with A=0xFFFFFF, B=0x000001; assert start again in cycle 3.
  - Required: only one done pulse, in cycle 8, with F=0xFFFFFE.
- Reset mid-operation:
  - Stimulus: rst=1 in cycle 4 of an active operation.
  - Required: next cycle busy=0 and all outputs 0, with no done pulse. A new start afterwards completes normally.
